// File: rtl/quiz_answer_arbiter_pkg.sv
// Shared types and helpers for the quiz answer arbiter.
// FSM state codes, the "no choice" code and the remote key index map.
package quiz_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_JUDGE   = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  localparam int CH_NONE = 0;

  // Player p (0-based), choice c (1-based), nc keys per remote.
  function automatic int key_bit(input int p, input int c, input int nc);
    return p * nc + c - 1;
  endfunction

endpackage

// File: rtl/quiz_answer_arbiter_if.sv
// Console-side bundle of the quiz answer arbiter.
// master drives keys and round control, slave returns judgements.
interface quiz_answer_arbiter_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_CHOICES = 4,
  parameter int SCORE_W     = 8
);
  localparam int PLY_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CH_W  = $clog2(NUM_CHOICES + 1);

  logic [NUM_PLAYERS*NUM_CHOICES-1:0] rm_in;
  logic [CH_W-1:0]                    prob;
  logic                               round_start;
  logic                               beep_busy;
  logic                               armed;
  logic                               ans_valid;
  logic [PLY_W-1:0]                   ans_player;
  logic [CH_W-1:0]                    ans_choice;
  logic                               ans_correct;
  logic [NUM_PLAYERS-1:0]             lockout;
  logic [NUM_PLAYERS*SCORE_W-1:0]     scores;
  logic                               next_problem;

  modport master (
    output rm_in, prob, round_start, beep_busy,
    input  armed, ans_valid, ans_player, ans_choice,
    input  ans_correct, lockout, scores, next_problem
  );

  modport slave (
    input  rm_in, prob, round_start, beep_busy,
    output armed, ans_valid, ans_player, ans_choice,
    output ans_correct, lockout, scores, next_problem
  );

endinterface

// File: rtl/quiz_answer_arbiter_edge.sv
// Remote key front end: registers raw keys and flags single-key presses.
// A press is exactly one key of a player going 1->0 in one cycle.
module remote_edge_decoder
  import quiz_pkg::*;
#(
  parameter int NP   = 2,
  parameter int NC   = 4,
  parameter int CH_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NP*NC-1:0]     i_rm_in,
  output logic [NP-1:0]        o_press_valid,
  output logic [NP*CH_W-1:0]   o_press_choice,
  output logic                 o_all_up
);

  logic [NP*NC-1:0]   r_rm;
  logic [NP*NC-1:0]   r_prev;
  logic [NP-1:0]      r_pv;
  logic [NP*CH_W-1:0] r_pc;
  logic [NP*NC-1:0]   w_fall;
  logic [NP-1:0]      w_pv;
  logic [NP*CH_W-1:0] w_pc;

  assign w_fall = r_prev & ~r_rm;

  always_comb begin
    w_pv = '0;
    w_pc = '0;
    for (int p = 0; p < NP; p++) begin
      w_pv[p] = ($countones(w_fall[p*NC +: NC]) == 1);
      for (int c = 1; c <= NC; c++) begin
        if (w_fall[key_bit(p, c, NC)])
          w_pc[p*CH_W +: CH_W] = CH_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rm   <= '1;
      r_prev <= '1;
      r_pv   <= '0;
      r_pc   <= '0;
    end else begin
      r_rm   <= i_rm_in;
      r_prev <= r_rm;
      r_pv   <= w_pv;
      r_pc   <= w_pc;
    end
  end

  assign o_press_valid  = r_pv;
  assign o_press_choice = r_pc;
  assign o_all_up       = &r_rm;

endmodule

// File: rtl/quiz_answer_arbiter.sv
// Quiz answer arbiter: first-press arbitration, judging, lockout, scores.
// Judgement outputs are registered and held until the next judgement.
module quiz_answer_arbiter
  import quiz_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_CHOICES = 4,
  parameter int SCORE_W     = 8,
  parameter int PLY_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  parameter int CH_W  = $clog2(NUM_CHOICES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  quiz_answer_arbiter_if.slave  bus
);

  state_t                 r_state;
  logic [CH_W-1:0]        r_prob;
  logic [NUM_PLAYERS-1:0] r_lock;
  logic [SCORE_W-1:0]     r_score [NUM_PLAYERS];
  logic                   r_armed;
  logic                   r_ans_valid;
  logic [PLY_W-1:0]       r_ans_player;
  logic [CH_W-1:0]        r_ans_choice;
  logic                   r_ans_correct;
  logic                   r_next;

  logic [NUM_PLAYERS-1:0]      w_pv;
  logic [NUM_PLAYERS*CH_W-1:0] w_pc;
  logic                        w_all_up;
  logic [NUM_PLAYERS-1:0]      w_elig;
  logic                        w_hit;
  logic [PLY_W-1:0]            w_win;
  logic [CH_W-1:0]             w_ch;
  logic                        w_good;
  logic [NUM_PLAYERS-1:0]      w_lock_nxt;
  logic                        w_close;

  remote_edge_decoder #(
    .NP   (NUM_PLAYERS),
    .NC   (NUM_CHOICES),
    .CH_W (CH_W)
  ) u_edge (
    .clk            (clk),
    .rst            (rst),
    .i_rm_in        (bus.rm_in),
    .o_press_valid  (w_pv),
    .o_press_choice (w_pc),
    .o_all_up       (w_all_up)
  );

  assign w_elig = w_pv & ~r_lock;
  assign w_hit  = |w_elig;

  // Descending scan so the lowest eligible player wins.
  always_comb begin
    w_win = '0;
    w_ch  = CH_W'(CH_NONE);
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (w_elig[p]) begin
        w_win = PLY_W'(p);
        w_ch  = w_pc[p*CH_W +: CH_W];
      end
    end
  end

  assign w_good     = (w_ch == r_prob);
  assign w_lock_nxt = r_lock | (NUM_PLAYERS'(1) << w_win);
  assign w_close    = w_good || (&w_lock_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_prob        <= '0;
      r_lock        <= '0;
      r_armed       <= 1'b0;
      r_ans_valid   <= 1'b0;
      r_ans_player  <= '0;
      r_ans_choice  <= '0;
      r_ans_correct <= 1'b0;
      r_next        <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++)
        r_score[p] <= '0;
    end else begin
      r_ans_valid <= 1'b0;
      r_next      <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.round_start) begin
            r_state <= ST_ARMED;
            r_prob  <= bus.prob;
            r_lock  <= '0;
            r_armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_hit && !bus.beep_busy) begin
            r_state       <= ST_JUDGE;
            r_ans_valid   <= 1'b1;
            r_ans_player  <= w_win;
            r_ans_choice  <= w_ch;
            r_ans_correct <= w_good;
            r_next        <= w_close;
            r_armed       <= !w_close;
            if (!w_good)
              r_lock <= w_lock_nxt;
            else if (r_score[w_win] != '1)
              r_score[w_win] <= r_score[w_win] + SCORE_W'(1);
          end
        end
        ST_JUDGE: begin
          r_state <= r_armed ? ST_ARMED : ST_RELEASE;
        end
        ST_RELEASE: begin
          if (w_all_up)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_sc
    assign bus.scores[g*SCORE_W +: SCORE_W] = r_score[g];
  end

  assign bus.armed        = r_armed;
  assign bus.ans_valid    = r_ans_valid;
  assign bus.ans_player   = r_ans_player;
  assign bus.ans_choice   = r_ans_choice;
  assign bus.ans_correct  = r_ans_correct;
  assign bus.lockout      = r_lock;
  assign bus.next_problem = r_next;

endmodule

// File: tb/tb_quiz_answer_arbiter.sv
// Scoreboard bench for quiz_answer_arbiter.
// Press events feed a round-level model; a monitor checks each judgement.
module tb_quiz_answer_arbiter;
  import quiz_pkg::*;

  localparam int NP = 2;
  localparam int NC = 4;
  localparam int SW = 8;
  localparam int MAXS = (1 << SW) - 1;

  typedef struct {
    int             cyc;
    int             ply;
    int             ch;
    bit             ok;
    int             score;
    logic [NP-1:0]  lock;
    bit             np;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t          q[$];
  int            m_state;
  int            m_prob;
  logic [NP-1:0] m_lock;
  int            m_score [NP];

  quiz_answer_arbiter_if #(
    .NUM_PLAYERS (NP), .NUM_CHOICES (NC), .SCORE_W (SW)
  ) bus ();

  quiz_answer_arbiter #(
    .NUM_PLAYERS (NP), .NUM_CHOICES (NC), .SCORE_W (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NP*NC-1:0] k1(input int p, input int c);
    logic [NP*NC-1:0] v;
    v = '0;
    v[key_bit(p, c, NC)] = 1'b1;
    return v;
  endfunction

  task automatic check_state();
    chk("armed", bus.armed, m_state == 1);
    chk("lockout", bus.lockout, m_lock);
    for (int p = 0; p < NP; p++)
      chk($sformatf("score%0d", p), bus.scores[p*SW +: SW], m_score[p]);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_prob  = 0;
    m_lock  = '0;
    for (int p = 0; p < NP; p++) m_score[p] = 0;
  endtask

  task automatic start_round(input int p);
    bus.prob = p[2:0];
    bus.round_start = 1'b1;
    tick(1);
    bus.round_start = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
      m_prob  = p;
      m_lock  = '0;
    end
    tick(2);
    check_state();
  endtask

  task automatic release_keys();
    bus.rm_in = '1;
    tick(5);
    if (m_state == 2) m_state = 0;
    check_state();
  endtask

  task automatic press(input logic [NP*NC-1:0] low, input bit busy,
                       input bit rel);
    exp_t          e;
    int            w;
    logic [NC-1:0] m;
    bus.rm_in = ~low;
    bus.beep_busy = busy;
    w = -1;
    if (m_state == 1 && !busy) begin
      for (int p = 0; p < NP; p++) begin
        m = low[p*NC +: NC];
        if (w < 0 && $countones(m) == 1 && !m_lock[p]) w = p;
      end
    end
    if (w >= 0) begin
      m = low[w*NC +: NC];
      e.cyc = cyc;
      e.ply = w;
      e.ch  = 0;
      for (int c = 1; c <= NC; c++) if (m[c-1]) e.ch = c;
      e.ok = (e.ch == m_prob);
      if (e.ok) begin
        if (m_score[w] < MAXS) m_score[w] = m_score[w] + 1;
      end else begin
        m_lock[w] = 1'b1;
      end
      e.score = m_score[w];
      e.lock  = m_lock;
      e.np    = e.ok || (&m_lock);
      if (e.np) m_state = 2;
      q.push_back(e);
    end
    tick(5);
    if (rel) begin
      bus.rm_in = '1;
      tick(5);
      if (m_state == 2) m_state = 0;
    end
    bus.beep_busy = 1'b0;
    tick(1);
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    chk("rst_armed", bus.armed, 0);
    chk("rst_valid", bus.ans_valid, 0);
    chk("rst_player", bus.ans_player, 0);
    chk("rst_choice", bus.ans_choice, 0);
    chk("rst_correct", bus.ans_correct, 0);
    chk("rst_lockout", bus.lockout, 0);
    chk("rst_scores", bus.scores, 0);
    chk("rst_next", bus.next_problem, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.ans_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ans: got player %0d choice %0d",
                   bus.ans_player, bus.ans_choice);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.cyc + 3);
          chk("ans_player", bus.ans_player, e.ply);
          chk("ans_choice", bus.ans_choice, e.ch);
          chk("ans_correct", bus.ans_correct, e.ok);
          chk("judge_score", bus.scores[e.ply*SW +: SW], e.score);
          chk("judge_lock", bus.lockout, e.lock);
          chk("next_problem", bus.next_problem, e.np);
          chk("judge_armed", bus.armed, !e.np);
        end
      end else if (bus.next_problem) begin
        tests++;
        fails++;
        $display("FAIL stray_next_problem: got 1 expected 0");
      end
    end
  end

  initial begin
    logic [NP*NC-1:0] low;
    logic [NC-1:0]    km;
    bus.rm_in = '1;
    bus.prob = '0;
    bus.round_start = 1'b0;
    bus.beep_busy = 1'b0;
    model_reset();
    tick(3);
    do_reset();
    check_state();

    start_round(3);
    press(k1(1, 3), 0, 1);

    start_round(2);
    press(k1(0, 4), 0, 1);
    press(k1(0, 2), 0, 1);
    press(k1(1, 2), 0, 1);

    start_round(1);
    press(k1(0, 4), 0, 1);
    press(k1(1, 4), 0, 0);
    start_round(3);
    release_keys();
    tick(2);

    start_round(1);
    press(k1(0, 1) | k1(1, 1), 0, 1);

    start_round(2);
    press(k1(0, 2), 1, 1);
    bus.beep_busy = 1'b1;
    bus.rm_in = ~k1(0, 2);
    tick(5);
    bus.beep_busy = 1'b0;
    tick(5);
    bus.rm_in = '1;
    tick(4);
    check_state();
    press(k1(0, 2), 0, 1);

    start_round(5);
    press(k1(0, 1) | k1(0, 2) | k1(1, 3), 0, 1);

    while (m_score[0] < MAXS) begin
      start_round(1);
      press(k1(0, 1), 0, 1);
    end
    start_round(1);
    press(k1(0, 1), 0, 1);

    start_round(1);
    do_reset();
    check_state();
    press(k1(0, 1), 0, 1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(3) == 0) begin
        start_round(int'($urandom_range(7)));
      end else begin
        low = '0;
        for (int p = 0; p < NP; p++) begin
          km = '0;
          case ($urandom_range(9))
            0, 1, 2, 3, 4: km = '0;
            5, 6, 7, 8: km[$urandom_range(NC - 1)] = 1'b1;
            default: km = NC'($urandom);
          endcase
          low[p*NC +: NC] = km;
        end
        press(low, $urandom_range(6) == 0, 1);
      end
    end

    tick(10);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
